div_sign_pipe: RTL and testbench

- Signed two's-complement fixed-point divider (Qm.Q): quotient = (dividend << Q) / divisor, truncated toward zero.
- Iterative restoring core retires R quotient bits per cycle, with valid/ready handshakes on both input and output.
- Adds flush, divide-by-zero detection, exact handling of the most-negative operand, and selectable saturate/wrap on overflow.
- Sits in the ALU next to the other arithmetic units and feeds fixed-point datapaths that need backpressure.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_core_uq.sv | 41 ++++
 rtl/div_sign_pipe.sv | 133 +++++++++++++
 tb/tb_div_sign_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the signed fixed-point divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic int iter_cnt(input int n, input int q, input int r);
    return (n + q) / r;
  endfunction

  // Saturation bit patterns of an n-bit two's-complement result.
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/div_core_uq.sv
// Unsigned restoring stage: R quotient bits per call, purely combinational.
module div_core_uq #(
  parameter int N = 32,
  parameter int W = 47,
  parameter int R = 1
) (
  input  logic [N-1:0] rem,
  input  logic [W-1:0] num,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_nxt,
  output logic [W-1:0] num_nxt,
  output logic [R-1:0] q
);

  always_comb begin
    logic [N:0]   trial;
    logic [N:0]   diff;
    logic [N-1:0] r;
    logic [W-1:0] n;
    r     = rem;
    n     = num;
    q     = '0;
    trial = '0;
    diff  = '0;
    // rem < dvs <= 2^(N-1), so the trial value never exceeds N significant bits
    for (int i = 0; i < R; i++) begin
      trial = {r, n[W-1]};
      n     = n << 1;
      diff  = trial - {1'b0, dvs};
      if (trial >= {1'b0, dvs}) begin
        r           = diff[N-1:0];
        q[R-1-i]    = 1'b1;
      end else begin
        r           = trial[N-1:0];
      end
    end
    rem_nxt = r;
    num_nxt = n;
  end

endmodule

// File: rtl/div_sign_pipe.sv
// Signed Qm.Q divider: sign-magnitude wrapper around an iterative restoring core,
// with valid/ready handshakes, flush, divide-by-zero and saturate/wrap overflow.
module div_sign_pipe
  import div_pkg::*;
#(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter int R   = 1,
  parameter int SAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_overflow,
  output logic         o_dbz
);

  localparam int W    = N + Q;
  localparam int ITER = iter_cnt(N, Q, R);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [N-1:0] QMAX  = N'(sat_max(N));
  localparam logic [N-1:0] QMIN  = N'(sat_min(N));
  localparam logic [W-1:0] LIM_P = W'(sat_max(N));
  localparam logic [W-1:0] LIM_N = W'(sat_min(N));

  if (!(R == 1 || R == 2 || R == 4) || ((N + Q) % R) != 0 || Q < 0 || Q >= N) begin : g_bad_cfg
    $error("div_sign_pipe: illegal N/Q/R combination");
  end

  state_e        state, state_d;
  logic [CW-1:0] cnt;
  logic          sign;
  logic [N-1:0]  dvs, rem, rem_nxt, mag_dvd, mag_dvs, res;
  logic [W-1:0]  num, num_nxt, quo, quo_nxt, quo_neg;
  logic [R-1:0]  qbits;
  logic          accept, out_hs, last, ovf, dvs_zero;

  assign o_ready  = (state == IDLE);
  assign accept   = i_valid && o_ready;
  assign out_hs   = o_valid && i_ready;
  assign last     = (cnt == CW'(1));
  assign dvs_zero = (i_divisor == '0);
  // N-bit negate maps -2^(N-1) onto the unsigned value 2^(N-1) exactly
  assign mag_dvd  = i_dividend[N-1] ? -i_dividend : i_dividend;
  assign mag_dvs  = i_divisor[N-1]  ? -i_divisor  : i_divisor;

  div_core_uq #(.N(N), .W(W), .R(R)) u_core (
    .rem     (rem),
    .num     (num),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .num_nxt (num_nxt),
    .q       (qbits)
  );

  assign quo_nxt = (quo << R) | W'(qbits);
  assign quo_neg = -quo_nxt;
  assign ovf     = sign ? (quo_nxt > LIM_N) : (quo_nxt > LIM_P);
  assign res     = (ovf && SAT != 0) ? (sign ? QMIN : QMAX)
                                     : (sign ? quo_neg[N-1:0] : quo_nxt[N-1:0]);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = dvs_zero ? DONE : CALC;
      CALC:    if (last)   state_d = DONE;
      DONE:    if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid    <= 1'b0;
      o_quotient <= '0;
      o_overflow <= 1'b0;
      o_dbz      <= 1'b0;
      cnt        <= '0;
      sign       <= 1'b0;
      dvs        <= '0;
      rem        <= '0;
      num        <= '0;
      quo        <= '0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_quotient <= '0;
      o_overflow <= 1'b0;
      o_dbz      <= 1'b0;
    end else begin
      // Result is registered on entry to DONE; o_valid follows one edge later
      o_valid <= (state == DONE) && !out_hs;
      unique case (state)
        IDLE: if (accept) begin
          sign       <= i_dividend[N-1] ^ i_divisor[N-1];
          dvs        <= mag_dvs;
          rem        <= '0;
          num        <= W'(mag_dvd) << Q;
          quo        <= '0;
          cnt        <= CW'(ITER);
          o_dbz      <= dvs_zero;
          o_overflow <= dvs_zero;
          o_quotient <= i_dividend[N-1] ? QMIN : QMAX;
        end
        CALC: begin
          rem <= rem_nxt;
          num <= num_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            o_quotient <= res;
            o_overflow <= ovf;
            o_dbz      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sign_pipe.sv
// Scoreboard bench for div_sign_pipe: three configurations (R=1 sat, R=4 sat, R=1 wrap).
module tb_div_sign_pipe;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  vin, rin, fl;
  logic [31:0] dvd [3];
  logic [31:0] dvs [3];
  logic [2:0]  ordy, ov, oovf, odbz;
  logic [31:0] oq  [3];

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // d0: Q15 R1 saturate, d1: Q16 R4 saturate (48 bits legal for R=4), d2: Q15 R1 wrap
  div_sign_pipe #(.N(32), .Q(15), .R(1), .SAT(1)) d0 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vin[0]), .o_ready(ordy[0]),
    .i_dividend(dvd[0]), .i_divisor(dvs[0]), .i_flush(fl[0]), .o_valid(ov[0]),
    .i_ready(rin[0]), .o_quotient(oq[0]), .o_overflow(oovf[0]), .o_dbz(odbz[0]));
  div_sign_pipe #(.N(32), .Q(16), .R(4), .SAT(1)) d1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vin[1]), .o_ready(ordy[1]),
    .i_dividend(dvd[1]), .i_divisor(dvs[1]), .i_flush(fl[1]), .o_valid(ov[1]),
    .i_ready(rin[1]), .o_quotient(oq[1]), .o_overflow(oovf[1]), .o_dbz(odbz[1]));
  div_sign_pipe #(.N(32), .Q(15), .R(1), .SAT(0)) d2 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vin[2]), .o_ready(ordy[2]),
    .i_dividend(dvd[2]), .i_divisor(dvs[2]), .i_flush(fl[2]), .o_valid(ov[2]),
    .i_ready(rin[2]), .o_quotient(oq[2]), .o_overflow(oovf[2]), .o_dbz(odbz[2]));

  function automatic exp_t mk(input logic [31:0] q, input logic ovf, input logic dbz);
    exp_t e;
    e.q = q; e.ovf = ovf; e.dbz = dbz;
    return e;
  endfunction

  // (N+Q)/R + 1 edges for a real divide, 1 edge for divide-by-zero
  function automatic int lat_for(input int d, input logic [31:0] b);
    if (b == 32'd0) return 1;
    return (d == 1) ? (48 / 4 + 1) : (47 + 1);
  endfunction

  // Reference: wide signed arithmetic, truncating toward zero
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int q, input bit sat);
    exp_t   e;
    longint sa, sb, num, qt;
    if (b == 32'd0) return mk(a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
    sa    = longint'(signed'(a));
    sb    = longint'(signed'(b));
    num   = sa * (longint'(1) << q);
    qt    = num / sb;
    e.dbz = 1'b0;
    e.ovf = (qt > 64'sd2147483647) || (qt < -64'sd2147483648);
    if (e.ovf && sat) e.q = (qt > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else              e.q = qt[31:0];
    return e;
  endfunction

  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, input bit push);
    vectors++;
    if (ordy[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready dut%0d: o_ready=%b, want 1", d, ordy[d]);
    end
    if (push) sbq.push_back(e);
    vin[d] = 1'b1; dvd[d] = a; dvs[d] = b;
    @(posedge clk); #1;
    vin[d] = 1'b0; dvd[d] = $urandom; dvs[d] = $urandom;
  endtask

  task automatic recv(input int d, input int exp_lat, input int hold, input string name);
    int   lat = 0;
    exp_t e;
    while (ov[d] !== 1'b1 && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency dut%0d: got %0d edges, want %0d", name, d, lat, exp_lat);
    end
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    vectors++;
    if (oq[d] !== e.q) begin
      miscompares++;
      $display("FAIL %s quotient dut%0d: got %h, want %h", name, d, oq[d], e.q);
    end
    vectors++;
    if ({oovf[d], odbz[d]} !== {e.ovf, e.dbz}) begin
      miscompares++;
      $display("FAIL %s flags dut%0d: ovf/dbz=%b%b, want %b%b", name, d, oovf[d], odbz[d], e.ovf, e.dbz);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({ov[d], ordy[d], oq[d], oovf[d], odbz[d]} !== {1'b1, 1'b0, e.q, e.ovf, e.dbz}) begin
        miscompares++;
        $display("FAIL %s hold%0d dut%0d: v=%b rdy=%b q=%h f=%b%b, want v=1 rdy=0 q=%h f=%b%b",
                 name, i, d, ov[d], ordy[d], oq[d], oovf[d], odbz[d], e.q, e.ovf, e.dbz);
      end
    end
    rin[d] = 1'b1;
    @(posedge clk); #1;
    rin[d] = 1'b0;
    vectors++;
    if (ov[d] !== 1'b0 || ordy[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release dut%0d: o_valid=%b o_ready=%b, want 0 1", name, d, ov[d], ordy[d]);
    end
  endtask

  task automatic op(input int d, input logic [31:0] a, input logic [31:0] b,
                    input exp_t e, input string name);
    send(d, a, b, e, 1'b1);
    recv(d, lat_for(d, b), 0, name);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({ov[d], oq[d], oovf[d], odbz[d], ordy[d]} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset dut%0d: v=%b q=%h f=%b%b rdy=%b, want 0 0 00 1",
                 d, ov[d], oq[d], oovf[d], odbz[d], ordy[d]);
      end
    end
  endtask

  task automatic test_basic();
    op(0, 32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 1'b0, 1'b0), "basic_r1");
    op(1, 32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0), "basic_r4");
  endtask

  task automatic test_sign();
    op(0, 32'hFFFE_8000, 32'h0001_0000, mk(32'hFFFF_4000, 1'b0, 1'b0), "neg_1p5");
    op(0, 32'h0000_8000, 32'h0001_8000, mk(32'h0000_2AAA, 1'b0, 1'b0), "trunc_pos");
    op(0, 32'hFFFF_8000, 32'h0001_8000, mk(32'hFFFF_D556, 1'b0, 1'b0), "trunc_neg");
  endtask

  task automatic test_most_neg();
    op(0, 32'h8000_0000, 32'h0000_8000, mk(32'h8000_0000, 1'b0, 1'b0), "minneg_exact");
    op(0, 32'h8000_0000, 32'hFFFF_8000, mk(32'h7FFF_FFFF, 1'b1, 1'b0), "minneg_sat");
    op(2, 32'h8000_0000, 32'hFFFF_8000, mk(32'h8000_0000, 1'b1, 1'b0), "minneg_wrap");
  endtask

  task automatic test_dbz();
    op(0, 32'h0002_8000, 32'h0, mk(32'h7FFF_FFFF, 1'b1, 1'b1), "dbz_pos");
    op(0, 32'hFFFF_0000, 32'h0, mk(32'h8000_0000, 1'b1, 1'b1), "dbz_neg");
    op(2, 32'hFFFF_0000, 32'h0, mk(32'h8000_0000, 1'b1, 1'b1), "dbz_wrap");
  endtask

  task automatic test_backpressure();
    send(0, 32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 1'b0, 1'b0), 1'b1);
    recv(0, 48, 5, "bp_hold");
    // next operand goes in straight after the handshake
    op(0, 32'h0000_8000, 32'h0001_8000, mk(32'h0000_2AAA, 1'b0, 1'b0), "bp_next");
  endtask

  task automatic test_flush();
    int seen = 0;
    send(0, 32'h0001_8000, 32'h0001_0000, mk(32'h0, 1'b0, 1'b0), 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    vectors++;
    if (ordy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_calc: o_ready=%b o_valid=%b, want 1 0", ordy[0], ov[0]);
    end
    repeat (60) begin @(posedge clk); #1; if (ov[0] === 1'b1) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL flush_no_valid: o_valid high %0d cycles, want 0", seen);
    end
    // flush in IDLE alongside i_valid must drop the operands
    fl[0] = 1'b1; vin[0] = 1'b1; dvd[0] = 32'h0001_0000; dvs[0] = 32'h0001_0000;
    @(posedge clk); #1;
    fl[0] = 1'b0; vin[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (ordy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: o_ready=%b o_valid=%b, want 1 0", ordy[0], ov[0]);
    end
    op(0, 32'hFFFE_8000, 32'h0001_0000, mk(32'hFFFF_4000, 1'b0, 1'b0), "post_flush");
  endtask

  task automatic test_reset_mid();
    send(0, 32'h0001_8000, 32'h0001_0000, mk(32'h0, 1'b0, 1'b0), 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({ov[0], oq[0], oovf[0], odbz[0], ordy[0]} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid: v=%b q=%h f=%b%b rdy=%b, want 0 0 00 1",
               ov[0], oq[0], oovf[0], odbz[0], ordy[0]);
    end
    rstn = 1'b1;
    op(0, 32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 1'b0, 1'b0), "post_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int          d;
    for (int i = 0; i < 16; i++) begin
      d = (i % 2 == 0) ? 0 : 2;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (i == 7) b = 32'd0;
      op(d, a, b, model(a, b, 15, d == 0), "random");
    end
  endtask

  initial begin
    rstn = 1'b0; vin = '0; rin = '0; fl = '0;
    for (int d = 0; d < 3; d++) begin dvd[d] = '0; dvs[d] = '0; end
    test_reset();
    test_basic();
    test_sign();
    test_most_neg();
    test_dbz();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
